// File: rtl/maze_pkg.sv
// Shared maze-game definitions: colour codes, RGB palette, screen size and
// the tile plotter state encoding.
package maze_pkg;

    localparam logic [1:0] COL_BG     = 2'd0;
    localparam logic [1:0] COL_PLAYER = 2'd1;
    localparam logic [1:0] COL_FROZEN = 2'd2;
    localparam logic [1:0] COL_HILITE = 2'd3;

    localparam logic [2:0] RGB_BG     = 3'b000;
    localparam logic [2:0] RGB_PLAYER = 3'b010;
    localparam logic [2:0] RGB_FROZEN = 3'b011;
    localparam logic [2:0] RGB_HILITE = 3'b111;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } plot_state_e;

    function automatic logic [2:0] colour_map(input logic [1:0] code);
        case (code)
            COL_BG:     return RGB_BG;
            COL_PLAYER: return RGB_PLAYER;
            COL_FROZEN: return RGB_FROZEN;
            default:    return RGB_HILITE;
        endcase
    endfunction

endpackage

// File: rtl/tile_plotter_if.sv
// Request side (from the game controller) and pixel-write side (to the VGA
// adapter) of the tile plotter, bundled as one interface.
interface tile_plotter_if #(
    parameter int CELL_XW = 6,
    parameter int CELL_YW = 5,
    parameter int X_W     = 8,
    parameter int Y_W     = 7
) ();
    logic               plot;
    logic [1:0]         s_color;
    logic [CELL_XW-1:0] xpos;
    logic [CELL_YW-1:0] ypos;
    logic [X_W-1:0]     vga_x;
    logic [Y_W-1:0]     vga_y;
    logic [2:0]         vga_colour;
    logic               vga_we;
    logic               busy;
    logic               done;

    modport master (
        output plot, s_color, xpos, ypos,
        input  vga_x, vga_y, vga_colour, vga_we, busy, done
    );

    modport slave (
        input  plot, s_color, xpos, ypos,
        output vga_x, vga_y, vga_colour, vga_we, busy, done
    );
endinterface

// File: rtl/tile_scan_counter.sv
// Row-major 2-D counter over a TILE x TILE square; cx wraps into a cy step.
module tile_scan_counter #(
    parameter int TILE = 4,
    parameter int CW   = $clog2(TILE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] cx,
    output logic [CW-1:0] cy,
    output logic          last
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx <= '0;
            cy <= '0;
        end else if (clear) begin
            cx <= '0;
            cy <= '0;
        end else if (enable) begin
            cx <= cx + 1'b1;
            if (&cx) cy <= cy + 1'b1;
        end
    end

    assign last = (&cx) & (&cy);

endmodule

// File: rtl/tile_plotter.sv
// Paints one TILE x TILE square per plot request as a pixel-per-clock write
// stream, clipping pixels that fall off the visible screen.
module tile_plotter
    import maze_pkg::*;
#(
    parameter int TILE     = 4,
    parameter int CELL_XW  = 6,
    parameter int CELL_YW  = 5,
    parameter int SCREEN_W = maze_pkg::SCREEN_W,
    parameter int SCREEN_H = maze_pkg::SCREEN_H,
    parameter int X_W      = 8,
    parameter int Y_W      = 7
) (
    input logic           clk,
    input logic           reset,
    tile_plotter_if.slave bus
);

    localparam int TW   = $clog2(TILE);
    localparam int BX_W = CELL_XW + TW;
    localparam int BY_W = CELL_YW + TW;

    plot_state_e     state, state_nxt;
    logic            load, emit_px, emit_done, cnt_clr, cnt_en;
    logic [TW-1:0]   cx, cy;
    logic            last;
    logic [BX_W-1:0] base_x_p0, src_x, px_x;
    logic [BY_W-1:0] base_y_p0, src_y, px_y;
    logic [2:0]      colour_p0, src_colour;
    logic            visible;
    logic [X_W-1:0]  vga_x_p1;
    logic [Y_W-1:0]  vga_y_p1;
    logic [2:0]      colour_p1;
    logic            we_p1, busy_p1, done_p1;

    tile_scan_counter #(.TILE(TILE), .CW(TW)) u_scan (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .cx     (cx),
        .cy     (cy),
        .last   (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // The counter always holds the pixel emitted at the next edge; the done
    // cycle is still visible on done_p1 while state is already IDLE, so a new
    // request is held off until the cycle after done.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        emit_px   = 1'b0;
        emit_done = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.plot && !done_p1) begin
                    load      = 1'b1;
                    emit_px   = 1'b1;
                    cnt_en    = 1'b1;
                    state_nxt = ST_DRAW;
                end
            end
            ST_DRAW: begin
                emit_px = 1'b1;
                cnt_en  = 1'b1;
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                emit_done = 1'b1;
                cnt_clr   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Base is tile-aligned, so adding the in-tile offset never carries out of
    // the widened coordinate and off-screen cells cannot alias on-screen.
    always_comb begin
        src_x      = load ? (BX_W'(bus.xpos) << TW) : base_x_p0;
        src_y      = load ? (BY_W'(bus.ypos) << TW) : base_y_p0;
        src_colour = load ? colour_map(bus.s_color) : colour_p0;
        px_x       = src_x + BX_W'(cx);
        px_y       = src_y + BY_W'(cy);
        visible    = (int'(px_x) < SCREEN_W) && (int'(px_y) < SCREEN_H);
    end

    // p0: request latch; p1: registered pixel-write outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_x_p0 <= '0;
            base_y_p0 <= '0;
            colour_p0 <= '0;
            vga_x_p1  <= '0;
            vga_y_p1  <= '0;
            colour_p1 <= '0;
            we_p1     <= 1'b0;
            busy_p1   <= 1'b0;
            done_p1   <= 1'b0;
        end else begin
            if (load) begin
                base_x_p0 <= src_x;
                base_y_p0 <= src_y;
                colour_p0 <= src_colour;
            end
            if (emit_px) begin
                vga_x_p1  <= X_W'(px_x);
                vga_y_p1  <= Y_W'(px_y);
                colour_p1 <= src_colour;
            end
            we_p1   <= emit_px & visible;
            busy_p1 <= emit_px | emit_done;
            done_p1 <= emit_done;
        end
    end

    assign bus.vga_x      = vga_x_p1;
    assign bus.vga_y      = vga_y_p1;
    assign bus.vga_colour = colour_p1;
    assign bus.vga_we     = we_p1;
    assign bus.busy       = busy_p1;
    assign bus.done       = done_p1;

endmodule

// File: doc/tile_plotter.md
Name: tile_plotter

Overview:
- Downstream of the game controller: turns its one-cycle `plot` request (with `s_color` and the player cell position) into a pixel-by-pixel write stream for the VGA frame-buffer adapter.
- Each request paints one TILE x TILE square at the pixel origin (xpos*TILE, ypos*TILE), emitting one pixel per clock.
- Reports `busy` while painting and pulses `done` when the square is finished.

Parameters:
- TILE, 4, tile edge in pixels; power of two, minimum 2.
- CELL_XW, 6, width of the cell-x input.
- CELL_YW, 5, width of the cell-y input.
- SCREEN_W, 160, visible width in pixels; pixels with x >= SCREEN_W are not written.
- SCREEN_H, 120, visible height in pixels; pixels with y >= SCREEN_H are not written.
- X_W, 8, VGA x coordinate width.
- Y_W, 7, VGA y coordinate width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; reset=0 clears all state immediately.
- plot  in  1  draw request; sampled only in IDLE.
- s_color  in  2  colour select: 0 = background, 1 = player, 2 = frozen, 3 = highlight.
- xpos  in  CELL_XW  cell x of the tile, sampled with plot.
- ypos  in  CELL_YW  cell y of the tile, sampled with plot.
- vga_x  out  X_W  pixel x.
- vga_y  out  Y_W  pixel y.
- vga_colour  out  3  RGB colour.
- vga_we  out  1  pixel write enable.
- busy  out  1  high in DRAW and DONE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, column and row counters=0, latched base/colour=0. Outputs: vga_x=0, vga_y=0, vga_colour=0, vga_we=0, busy=0, done=0.
- Outputs are driven only from registers; there is no combinational path from inputs to outputs.
- Colour map for vga_colour:
  - s_color 0 -> 3'b000
  - s_color 1 -> 3'b010
  - s_color 2 -> 3'b011
  - s_color 3 -> 3'b111
- IDLE:
  - plot=1 at an edge latches base_x=xpos*TILE, base_y=ypos*TILE and the mapped colour, clears both counters, and moves to DRAW.
  - plot=0 stays in IDLE.
- DRAW, one pixel per cycle:
  - vga_x = base_x + cx and vga_y = base_y + cy, computed at full width before truncation.
  - vga_we = 1 only if the full-width x < SCREEN_W and y < SCREEN_H. Clipped pixels still consume their cycle.
  - Scan is row-major: cx counts 0..TILE-1; when it wraps, cy increments.
  - After the pixel at cx=cy=TILE-1, move to DONE.
- DONE: done=1 and vga_we=0 for exactly one cycle, then return to IDLE.
- Latency and throughput:
  - The first pixel is presented in the cycle after plot is accepted.
  - The last pixel is presented TILE*TILE cycles after acceptance.
  - done is high on cycle TILE*TILE+1.
  - The next request can be accepted in the cycle after done.
- plot while busy: ignored, not queued. A level-held plot (as issued in the controller's FROZEN state) therefore redraws every TILE*TILE+2 cycles.
- Changes to xpos, ypos or s_color during DRAW have no effect on the tile being drawn.
- Reset asserted mid-DRAW: vga_we and busy drop immediately and no done pulse is issued.
- Clipping arithmetic: base coordinates use CELL_*W+log2(TILE) bits, so a large cell index never wraps into the visible area.

Decomposition:
- Shared package `maze_pkg` holds:
  - colour codes COL_BG=0, COL_PLAYER=1, COL_FROZEN=2, COL_HILITE=3, and the 3-bit RGB palette constants;
  - SCREEN_W and SCREEN_H;
  - state encodings ST_IDLE, ST_DRAW, ST_DONE.
- One sub-module, `tile_scan_counter`: a parameterised row-major 2-D counter with inputs clear and enable, outputs cx, cy and last.
- The FSM, latch registers and clipping logic stay in `tile_plotter`.

Test Plan (TILE=4):
- Draw at origin: reset, then plot=1 for one cycle with xpos=0, ypos=0, s_color=1.
  - Expect 16 cycles of vga_we=1 with (x,y) = (0,0),(1,0),...,(3,0),(0,1),...,(3,3) and vga_colour=3'b010.
  - Expect done high on cycle 17 and busy low on cycle 18.
- Right edge: xpos=39, ypos=29, s_color=0.
  - Expect 16 writes covering x=156..159, y=116..119 with colour 000.
- Fully clipped: xpos=40, ypos=0.
  - Expect vga_we=0 for all 16 pixel cycles, busy high throughout, done on cycle 17.
- Request while busy: plot pulses with xpos=5 at cycles 3 and 10 of a draw at xpos=1.
  - Expect only x=4..7 to be written, a single done, and no second tile.
- Held plot with s_color=2 for 40 cycles.
  - Expect back-to-back tiles in colour 3'b011, with new draws accepted at cycles 0 and 18, and 36.
- Reset mid-draw: assert reset=0 asynchronously at pixel 7.
  - Expect vga_we, busy and done to be 0 before the next clk edge.
  - After release, IDLE; a new plot then draws all 16 pixels from (base_x,base_y).
